spi_cs_sequencer: RTL and testbench

Clocked, parametrised successor to the combinational SPI chip-select decoder. It decodes a binary slave select into NUM_OUT_LINES active-low chip selects and enforces programmable CS-to-SCLK setup, SCLK-to-CS hold and minimum deselect gap timing. It sits between the SPI master's select and enable outputs and the board-level CSn pins. It returns a cs_ready handshake so the master starts clocking only once setup time has elapsed.

---
 rtl/spi_cs_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_spi_cs_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cs_sequencer.sv
// spi_cs_sequencer
// Clocked chip-select sequencer. It decodes a binary slave index into
// NUM_OUT_LINES active-low chip selects and enforces CS-to-SCLK setup,
// SCLK-to-CS hold and a minimum all-deselected gap between transactions.
//
// Ports:
//   clk                  block clock, rising edge
//   rst                  asynchronous active-high reset
//   spi_select           binary slave index, sampled only in IDLE
//   spi_master_active_n  master transaction request, active-low
//   spi_csn              registered chip selects, active-low, at most one low
//   cs_ready             registered, high only in ACTIVE (master may clock SCLK)
//   busy                 registered, high in every state except IDLE
//   sel_err              (SPI_CS_SEQ_ERR_EN only) sticky out-of-range select flag
//   err_clr              (SPI_CS_SEQ_ERR_EN only) clears sel_err; a new error wins
//
// Optional feature macro: SPI_CS_SEQ_ERR_EN. When defined, an out-of-range
// select sets sel_err and goes straight to GAP without granting cs_ready.
// When undefined, an out-of-range select runs the full sequence with no CSn low.

module spi_cs_sequencer #(
    parameter int unsigned NUM_OUT_LINES = 8,
    parameter int unsigned SEL_WIDTH     = 3,
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned HOLD_CYCLES   = 2,
    parameter int unsigned GAP_CYCLES    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SEL_WIDTH-1:0]     spi_select,
    input  logic                     spi_master_active_n,
`ifdef SPI_CS_SEQ_ERR_EN
    output logic                     sel_err,
    input  logic                     err_clr,
`endif
    output logic [NUM_OUT_LINES-1:0] spi_csn,
    output logic                     cs_ready,
    output logic                     busy
);

    localparam int unsigned MAX_SH  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_SH > GAP_CYCLES) ? MAX_SH : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(((MAX_CYC > 0) ? MAX_CYC : 1) + 1);

    // Counters load N-1 on entry and the state exits on the edge that sees zero,
    // so each timed state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYCLES  > 0) ? HOLD_CYCLES  - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_CYCLES   > 0) ? GAP_CYCLES   - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACTIVE,
        S_HOLD,
        S_GAP
    } state_t;

    // Where a deselect lands: GAP, or straight back to IDLE when no gap is required.
    localparam state_t GAP_NEXT = (GAP_CYCLES != 0) ? S_GAP : S_IDLE;
    localparam logic   GAP_BUSY = (GAP_CYCLES != 0) ? 1'b1 : 1'b0;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [SEL_WIDTH-1:0] sel_q;
    logic [NUM_OUT_LINES-1:0] sel_csn_c;

    // One-cold decode of the incoming select; out-of-range indices decode to all high.
    always_comb begin
        sel_csn_c = '1;
        for (int unsigned i = 0; i < NUM_OUT_LINES; i++) begin
            sel_csn_c[i] = (SEL_WIDTH'(i) != spi_select);
        end
    end

`ifdef SPI_CS_SEQ_ERR_EN
    logic sel_ok_c;

    // Select range check; widened by one bit so NUM_OUT_LINES = 2**SEL_WIDTH fits.
    assign sel_ok_c = ({1'b0, spi_select} < (SEL_WIDTH + 1)'(NUM_OUT_LINES));
`endif

    // Sequencer state, timing counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sel_q    <= '0;
            spi_csn  <= '1;
            cs_ready <= 1'b0;
            busy     <= 1'b0;
`ifdef SPI_CS_SEQ_ERR_EN
            sel_err  <= 1'b0;
`endif
        end else begin
`ifdef SPI_CS_SEQ_ERR_EN
            // Clear first so a same-edge error set below takes precedence.
            if (err_clr) begin
                sel_err <= 1'b0;
            end
`endif
            case (state)
                S_IDLE: begin
                    if (!spi_master_active_n) begin
                        sel_q <= spi_select;
                        busy  <= 1'b1;
`ifdef SPI_CS_SEQ_ERR_EN
                        if (!sel_ok_c) begin
                            sel_err <= 1'b1;
                            state   <= GAP_NEXT;
                            cnt     <= GAP_LD;
                            busy    <= GAP_BUSY;
                        end else
`endif
                        if (SETUP_CYCLES != 0) begin
                            state   <= S_SETUP;
                            cnt     <= SETUP_LD;
                            spi_csn <= sel_csn_c;
                        end else begin
                            state    <= S_ACTIVE;
                            cs_ready <= 1'b1;
                            spi_csn  <= sel_csn_c;
                        end
                    end
                end

                S_SETUP: begin
                    // A release during setup aborts: deselect now, skip HOLD.
                    if (spi_master_active_n) begin
                        state   <= GAP_NEXT;
                        cnt     <= GAP_LD;
                        busy    <= GAP_BUSY;
                        spi_csn <= '1;
                    end else if (cnt == '0) begin
                        state    <= S_ACTIVE;
                        cs_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                S_ACTIVE: begin
                    if (spi_master_active_n) begin
                        cs_ready <= 1'b0;
                        if (HOLD_CYCLES != 0) begin
                            state <= S_HOLD;
                            cnt   <= HOLD_LD;
                        end else begin
                            state   <= GAP_NEXT;
                            cnt     <= GAP_LD;
                            busy    <= GAP_BUSY;
                            spi_csn <= '1;
                        end
                    end
                end

                S_HOLD: begin
                    if (cnt == '0) begin
                        state   <= GAP_NEXT;
                        cnt     <= GAP_LD;
                        busy    <= GAP_BUSY;
                        spi_csn <= '1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                S_GAP: begin
                    // Requests are ignored here; a held request is seen in IDLE.
                    if (cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    cnt      <= '0;
                    spi_csn  <= '1;
                    cs_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Directed testbench for spi_cs_sequencer: default timing instance, an
// all-zero-timing instance and a 6-line instance for out-of-range selects.

module tb_spi_cs_sequencer;

    logic clk = 1'b0;
    logic rst;

    logic [2:0] sel,  osel,  zsel;
    logic       an,   oan,   zan;
    logic [7:0] csn;
    logic [5:0] ocsn, zcsn;
    logic       rdy,  ordy,  zrdy;
    logic       bsy,  obsy,  zbsy;
`ifdef SPI_CS_SEQ_ERR_EN
    logic       err,  oerr,  zerr;
    logic       oclr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_cs_sequencer u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .spi_select          (sel),
        .spi_master_active_n (an),
`ifdef SPI_CS_SEQ_ERR_EN
        .sel_err             (err),
        .err_clr             (1'b0),
`endif
        .spi_csn             (csn),
        .cs_ready            (rdy),
        .busy                (bsy)
    );

    spi_cs_sequencer #(
        .NUM_OUT_LINES (6),
        .SEL_WIDTH     (3),
        .SETUP_CYCLES  (0),
        .HOLD_CYCLES   (0),
        .GAP_CYCLES    (0)
    ) u_zero (
        .clk                 (clk),
        .rst                 (rst),
        .spi_select          (zsel),
        .spi_master_active_n (zan),
`ifdef SPI_CS_SEQ_ERR_EN
        .sel_err             (zerr),
        .err_clr             (1'b0),
`endif
        .spi_csn             (zcsn),
        .cs_ready            (zrdy),
        .busy                (zbsy)
    );

    spi_cs_sequencer #(
        .NUM_OUT_LINES (6),
        .SEL_WIDTH     (3)
    ) u_oor (
        .clk                 (clk),
        .rst                 (rst),
        .spi_select          (osel),
        .spi_master_active_n (oan),
`ifdef SPI_CS_SEQ_ERR_EN
        .sel_err             (oerr),
        .err_clr             (oclr),
`endif
        .spi_csn             (ocsn),
        .cs_ready            (ordy),
        .busy                (obsy)
    );

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sel = 3'd0; an = 1'b1;
        osel = 3'd0; oan = 1'b1;
        zsel = 3'd0; zan = 1'b1;
`ifdef SPI_CS_SEQ_ERR_EN
        oclr = 1'b0;
`endif
        tick();
        tick();
        n_checks++; if (csn !== 8'hFF) begin n_fail++; $display("FAIL reset_csn got=%h exp=FF", csn); end
        n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", rdy); end
        n_checks++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bsy); end
        n_checks++; if (zcsn !== 6'h3F) begin n_fail++; $display("FAIL reset_zcsn got=%h exp=3F", zcsn); end
`ifdef SPI_CS_SEQ_ERR_EN
        n_checks++; if (oerr !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err got=%b exp=0", oerr); end
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_checks++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got=%b exp=0", bsy); end
    endtask

    task automatic test_basic();
        logic rdy_seen;
        sel = 3'd5; an = 1'b0;
        tick(); // edge 0
        n_checks++; if (csn !== 8'hDF) begin n_fail++; $display("FAIL basic_csn_e0 got=%h exp=DF", csn); end
        n_checks++; if (bsy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_e0 got=%b exp=1", bsy); end
        n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL basic_ready_e0 got=%b exp=0", rdy); end
        tick(); // edge 1
        n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL basic_ready_e1 got=%b exp=0", rdy); end
        tick(); // edge 2
        n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL basic_ready_e2 got=%b exp=1", rdy); end
        for (int e = 3; e <= 9; e++) tick();
        n_checks++; if (csn !== 8'hDF || rdy !== 1'b1) begin n_fail++; $display("FAIL basic_active_e9 got csn=%h rdy=%b exp DF 1", csn, rdy); end
        an = 1'b1;
        tick(); // edge 10
        n_checks++; if (rdy !== 1'b0 || csn !== 8'hDF) begin n_fail++; $display("FAIL basic_hold_e10 got csn=%h rdy=%b exp DF 0", csn, rdy); end
        tick(); // edge 11
        n_checks++; if (csn !== 8'hDF) begin n_fail++; $display("FAIL basic_hold_e11 got=%h exp=DF", csn); end
        tick(); // edge 12
        n_checks++; if (csn !== 8'hFF) begin n_fail++; $display("FAIL basic_gap_e12 got=%h exp=FF", csn); end
        rdy_seen = 1'b0;
        for (int e = 13; e <= 15; e++) begin
            tick();
            if (bsy !== 1'b1) rdy_seen = 1'b1;
        end
        n_checks++; if (rdy_seen !== 1'b0) begin n_fail++; $display("FAIL basic_gap_busy got=early_idle exp=busy_through_e15"); end
        tick(); // edge 16
        n_checks++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_e16 got=%b exp=0", bsy); end
    endtask

    task automatic test_back_to_back();
        sel = 3'd5; an = 1'b0;
        for (int e = 0; e <= 9; e++) tick();
        an = 1'b1;
        tick(); // edge 10
        sel = 3'd3; an = 1'b0;
        tick(); // edge 11
        n_checks++; if (csn !== 8'hDF) begin n_fail++; $display("FAIL b2b_hold_e11 got=%h exp=DF", csn); end
        for (int e = 12; e <= 16; e++) begin
            tick();
            n_checks++; if (csn !== 8'hFF) begin n_fail++; $display("FAIL b2b_no_fall_e%0d got=%h exp=FF", e, csn); end
        end
        tick(); // edge 17
        n_checks++; if (csn !== 8'hF7) begin n_fail++; $display("FAIL b2b_new_csn_e17 got=%h exp=F7", csn); end
        an = 1'b1;
        for (int e = 18; e <= 22; e++) tick();
        n_checks++; if (bsy !== 1'b0 || csn !== 8'hFF) begin n_fail++; $display("FAIL b2b_drain got busy=%b csn=%h exp 0 FF", bsy, csn); end
    endtask

    task automatic test_abort();
        logic rdy_seen;
        sel = 3'd1; an = 1'b0;
        tick(); // edge 0
        n_checks++; if (csn !== 8'hFD) begin n_fail++; $display("FAIL abort_csn_e0 got=%h exp=FD", csn); end
        an = 1'b1;
        tick(); // edge 1
        n_checks++; if (csn !== 8'hFF) begin n_fail++; $display("FAIL abort_csn_e1 got=%h exp=FF", csn); end
        rdy_seen = rdy;
        for (int e = 2; e <= 4; e++) begin
            tick();
            rdy_seen = rdy_seen | rdy;
            n_checks++; if (bsy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_e%0d got=%b exp=1", e, bsy); end
        end
        n_checks++; if (rdy_seen !== 1'b0) begin n_fail++; $display("FAIL abort_ready got=%b exp=0", rdy_seen); end
        tick(); // edge 5
        n_checks++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_e5 got=%b exp=0", bsy); end
    endtask

    task automatic test_select_change_reset();
        sel = 3'd5; an = 1'b0;
        tick(); tick(); tick();
        sel = 3'd2;
        tick(); tick();
        n_checks++; if (csn !== 8'hDF || rdy !== 1'b1) begin n_fail++; $display("FAIL selchg_csn got csn=%h rdy=%b exp DF 1", csn, rdy); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (csn !== 8'hFF || rdy !== 1'b0) begin n_fail++; $display("FAIL async_rst got csn=%h rdy=%b exp FF 0", csn, rdy); end
        an = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_checks++; if (bsy !== 1'b0 || csn !== 8'hFF) begin n_fail++; $display("FAIL rst_release got busy=%b csn=%h exp 0 FF", bsy, csn); end
    endtask

    task automatic test_zero_timing();
        zsel = 3'd0; zan = 1'b0;
        tick();
        n_checks++; if (zcsn !== 6'h3E || zrdy !== 1'b1) begin n_fail++; $display("FAIL zero_start got csn=%h rdy=%b exp 3E 1", zcsn, zrdy); end
        zan = 1'b1;
        tick();
        n_checks++; if (zcsn !== 6'h3F || zrdy !== 1'b0) begin n_fail++; $display("FAIL zero_release got csn=%h rdy=%b exp 3F 0", zcsn, zrdy); end
        n_checks++; if (zbsy !== 1'b0) begin n_fail++; $display("FAIL zero_idle got=%b exp=0", zbsy); end
    endtask

    task automatic test_out_of_range();
        logic low_seen;
        osel = 3'd7; oan = 1'b0;
        tick(); // edge 0
        n_checks++; if (ocsn !== 6'h3F || obsy !== 1'b1) begin n_fail++; $display("FAIL oor_e0 got csn=%h busy=%b exp 3F 1", ocsn, obsy); end
`ifdef SPI_CS_SEQ_ERR_EN
        n_checks++; if (oerr !== 1'b1) begin n_fail++; $display("FAIL oor_sel_err got=%b exp=1", oerr); end
        oan = 1'b1;
        low_seen = ordy;
        for (int e = 1; e <= 3; e++) begin
            tick();
            low_seen = low_seen | ordy | ~(&ocsn);
        end
        n_checks++; if (low_seen !== 1'b0) begin n_fail++; $display("FAIL oor_err_quiet got=%b exp=0", low_seen); end
        tick(); // edge 4
        n_checks++; if (obsy !== 1'b0) begin n_fail++; $display("FAIL oor_err_idle got=%b exp=0", obsy); end
        n_checks++; if (oerr !== 1'b1) begin n_fail++; $display("FAIL oor_err_sticky got=%b exp=1", oerr); end
        oclr = 1'b1;
        tick();
        oclr = 1'b0;
        n_checks++; if (oerr !== 1'b0) begin n_fail++; $display("FAIL oor_err_clr got=%b exp=0", oerr); end
`else
        tick(); tick(); // edges 1, 2
        n_checks++; if (ordy !== 1'b1 || ocsn !== 6'h3F) begin n_fail++; $display("FAIL oor_ready got rdy=%b csn=%h exp 1 3F", ordy, ocsn); end
        oan = 1'b1;
        low_seen = 1'b0;
        for (int e = 3; e <= 8; e++) begin
            tick();
            low_seen = low_seen | ~(&ocsn);
        end
        n_checks++; if (low_seen !== 1'b0) begin n_fail++; $display("FAIL oor_csn_high got=%b exp=0", low_seen); end
        n_checks++; if (obsy !== 1'b1) begin n_fail++; $display("FAIL oor_gap_e8 got=%b exp=1", obsy); end
        tick(); // edge 9
        n_checks++; if (obsy !== 1'b0) begin n_fail++; $display("FAIL oor_idle_e9 got=%b exp=0", obsy); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_select_change_reset();
        test_zero_timing();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
